// File: rtl/iommu_ip_ctrl_pkg.sv
// Shared definitions for the IOMMU interrupt-pending controller: ipsr layout,
// vector count and a vector decode helper.
package iommu_pkg;

    localparam int unsigned N_VEC = 16;
    localparam int unsigned VEC_W = $clog2(N_VEC);

    localparam int unsigned IPSR_CIP  = 0;
    localparam int unsigned IPSR_FIP  = 1;
    localparam int unsigned IPSR_PMIP = 2;

    // Field order places cip in bit 0 so the struct overlays ipsr directly.
    typedef struct packed {
        logic pmip;
        logic fip;
        logic cip;
    } ipsr_t;

    function automatic logic [N_VEC-1:0] vec_decode(input logic hit, input logic [VEC_W-1:0] vec);
        logic [N_VEC-1:0] onehot;
        onehot = '0;
        for (int unsigned v = 0; v < N_VEC; v++) begin
            if (hit && (vec == VEC_W'(v))) begin
                onehot[v] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/iommu_ip_ctrl_if.sv
// Status/ipsr/vector bundle between the CSR block and the interrupt-pending
// controller; wsi lines exist only when IOMMU_WSI_EN is defined.
interface iommu_ip_ctrl_if;
    import iommu_pkg::*;

    logic             cq_ie;
    logic             cq_fence_w_ip;
    logic             cq_cmd_ill;
    logic             cq_cmd_to;
    logic             cq_mf;
    logic             fq_ie;
    logic             fq_of;
    logic             fq_mf;
    logic             pm_ovf;
    logic             ipsr_we;
    logic [2:0]       ipsr_wdata;
    logic [VEC_W-1:0] civ;
    logic [VEC_W-1:0] fiv;
    logic [VEC_W-1:0] pmiv;
    logic             wsi_en;
    logic             cip;
    logic             fip;
    logic             pmip;
    logic             msi_ig_en;
`ifdef IOMMU_WSI_EN
    logic [N_VEC-1:0] wsi;
`endif

    modport master (
        output cq_ie, cq_fence_w_ip, cq_cmd_ill, cq_cmd_to, cq_mf,
        output fq_ie, fq_of, fq_mf, pm_ovf, ipsr_we, ipsr_wdata,
        output civ, fiv, pmiv, wsi_en,
`ifdef IOMMU_WSI_EN
        input  wsi,
`endif
        input  cip, fip, pmip, msi_ig_en
    );

    modport slave (
        input  cq_ie, cq_fence_w_ip, cq_cmd_ill, cq_cmd_to, cq_mf,
        input  fq_ie, fq_of, fq_mf, pm_ovf, ipsr_we, ipsr_wdata,
        input  civ, fiv, pmiv, wsi_en,
`ifdef IOMMU_WSI_EN
        output wsi,
`endif
        output cip, fip, pmip, msi_ig_en
    );

endinterface

// File: rtl/iommu_ip_ctrl_bit.sv
// One ipsr pending bit: rising-edge (or raw pulse) set, W1C clear, set wins
// over clear, asynchronous active-low reset.
module iommu_ip_bit #(
    parameter bit PULSE_MODE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic clr_i,
    output logic pend_o
);

    logic set_evt;
    logic pend_d;
    logic pend_q;

    generate
        if (PULSE_MODE) begin : g_pulse
            assign set_evt = set_i;
        end else begin : g_edge
            // History resets to 0, so a condition already high out of reset is an edge.
            logic hist_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    hist_q <= 1'b0;
                end else begin
                    hist_q <= set_i;
                end
            end
            assign set_evt = set_i & ~hist_q;
        end
    endgenerate

    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end
        if (set_evt) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/iommu_ip_ctrl.sv
// IOMMU interrupt-pending controller: CQ/FQ/HPM conditions -> ipsr cip/fip/pmip,
// MSI enable to the generator. Optional wired interrupts under IOMMU_WSI_EN.
module iommu_ip_ctrl
    import iommu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    iommu_ip_ctrl_if.slave   ip_if
);

    logic  cq_cond;
    logic  fq_cond;
    ipsr_t clr;
    ipsr_t pend;

    assign cq_cond = ip_if.cq_ie & (ip_if.cq_fence_w_ip | ip_if.cq_cmd_ill |
                                    ip_if.cq_cmd_to | ip_if.cq_mf);
    assign fq_cond = ip_if.fq_ie & (ip_if.fq_of | ip_if.fq_mf);
    assign clr     = ip_if.ipsr_we ? ipsr_t'(ip_if.ipsr_wdata) : ipsr_t'('0);

    iommu_ip_bit #(.PULSE_MODE(1'b0)) u_cip (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .set_i  (cq_cond),
        .clr_i  (clr.cip),
        .pend_o (pend.cip)
    );

    iommu_ip_bit #(.PULSE_MODE(1'b0)) u_fip (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .set_i  (fq_cond),
        .clr_i  (clr.fip),
        .pend_o (pend.fip)
    );

    iommu_ip_bit #(.PULSE_MODE(1'b1)) u_pmip (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .set_i  (ip_if.pm_ovf),
        .clr_i  (clr.pmip),
        .pend_o (pend.pmip)
    );

    assign ip_if.cip  = pend.cip;
    assign ip_if.fip  = pend.fip;
    assign ip_if.pmip = pend.pmip;

`ifdef IOMMU_WSI_EN
    logic [N_VEC-1:0] wsi_d;
    logic [N_VEC-1:0] wsi_q;

    always_comb begin
        wsi_d = '0;
        if (ip_if.wsi_en) begin
            wsi_d = vec_decode(pend.cip,  ip_if.civ) |
                    vec_decode(pend.fip,  ip_if.fiv) |
                    vec_decode(pend.pmip, ip_if.pmiv);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wsi_q <= '0;
        end else begin
            wsi_q <= wsi_d;
        end
    end

    assign ip_if.wsi       = wsi_q;
    assign ip_if.msi_ig_en = ~ip_if.wsi_en;
`else
    // Without wired interrupts MSI is the only delivery path.
    logic unused_wsi;
    assign unused_wsi      = ip_if.wsi_en ^ (^ip_if.civ) ^ (^ip_if.fiv) ^ (^ip_if.pmiv);
    assign ip_if.msi_ig_en = 1'b1;
`endif

endmodule
